// File: rtl/hazard_pkg.sv
// hazard_pkg: opcode/funct constants, select encodings and instruction class record
package hazard_pkg;
    localparam logic [5:0] OP_R = 6'h00, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_LUI = 6'h0f;
    localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23;
    localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;
    localparam logic [5:0] F_JR = 6'h08, F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2a, F_SLTU = 6'h2b;

    localparam int TW = 2;
    typedef logic [TW-1:0] t_t;
    // a source that is never read gets a Tuse no Tnew can exceed
    localparam t_t TUSE_NONE = 2'd3;

    typedef enum logic [1:0] {SEL_RF, SEL_E_PC8, SEL_M_RES, SEL_M_PC8} dsel_e;
    typedef enum logic [2:0] {SEL_E_REG, SEL_E_M_RES, SEL_E_M_PC8, SEL_E_W_WD} esel_e;
    typedef enum logic {SEL_DM_REG, SEL_DM_W_WD} msel_e;

    typedef struct packed {
        logic [4:0] dst;
        logic [4:0] rs;
        logic [4:0] rt;
        t_t         tuse_rs;
        t_t         tuse_rt;
        t_t         tnew;
        logic       is_md;
        logic       is_md_start;
        logic       is_jal;
    } cls_t;

    function automatic logic hit(input logic [4:0] dst, input logic [4:0] r);
        return r != 5'd0 && dst == r;
    endfunction

    function automatic t_t tnew_m(input t_t t);
        return t == '0 ? '0 : t - 1'b1;
    endfunction

    function automatic logic stall_on(input logic [4:0] r, input t_t tuse, input logic [4:0] e_dst,
                                      input t_t e_tnew, input logic [4:0] m_dst, input t_t m_tnew);
        return (hit(e_dst, r) && e_tnew > tuse) || (hit(m_dst, r) && tnew_m(m_tnew) > tuse);
    endfunction

    function automatic dsel_e fwd_d(input logic [4:0] r, input logic [4:0] e_dst, input t_t e_tnew,
                                    input logic [4:0] m_dst, input t_t m_tnew, input logic m_jal);
        return (hit(e_dst, r) && e_tnew == '0) ? SEL_E_PC8 :
               (hit(m_dst, r) && tnew_m(m_tnew) == '0) ? (m_jal ? SEL_M_PC8 : SEL_M_RES) : SEL_RF;
    endfunction

    function automatic esel_e fwd_e(input logic [4:0] r, input logic [4:0] m_dst, input t_t m_tnew,
                                    input logic m_jal, input logic [4:0] w_dst);
        return (hit(m_dst, r) && tnew_m(m_tnew) == '0) ? (m_jal ? SEL_E_M_PC8 : SEL_E_M_RES) :
               hit(w_dst, r) ? SEL_E_W_WD : SEL_E_REG;
    endfunction
endpackage

// File: rtl/hazard_ctrl_instr_class.sv
// instr_class: decodes one instruction word into destination, sources, Tuse and Tnew
module instr_class
    import hazard_pkg::*;
(
    input  logic [31:0] ir,
    output cls_t        c
);
    logic [5:0] op, fn;
    logic r, r_alu, md_st, mf, mt, jr, i_alu_rs, lui, ld, st, br, jal;
    logic unused_shamt;

    assign op = ir[31:26];
    assign fn = ir[5:0];
    assign unused_shamt = ^ir[10:6];
    assign r        = op == OP_R;
    assign r_alu    = r && (fn inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLTU});
    assign md_st    = r && (fn inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
    assign mf       = r && (fn inside {F_MFHI, F_MFLO});
    assign mt       = r && (fn inside {F_MTHI, F_MTLO});
    assign jr       = r && fn == F_JR;
    assign i_alu_rs = op inside {OP_ADDI, OP_ANDI, OP_ORI};
    assign lui      = op == OP_LUI;
    assign ld       = op inside {OP_LB, OP_LH, OP_LW};
    assign st       = op inside {OP_SB, OP_SH, OP_SW};
    assign br       = op inside {OP_BEQ, OP_BNE};
    assign jal      = op == OP_JAL;

    assign c.dst = (r_alu || mf) ? ir[15:11] : (i_alu_rs || lui || ld) ? ir[20:16] : jal ? 5'd31 : 5'd0;
    assign c.tuse_rs = (br || jr) ? 2'd0 : (r_alu || md_st || mt || i_alu_rs || ld || st) ? 2'd1 : TUSE_NONE;
    assign c.tuse_rt = br ? 2'd0 : (r_alu || md_st) ? 2'd1 : st ? 2'd2 : TUSE_NONE;
    assign c.rs = c.tuse_rs == TUSE_NONE ? 5'd0 : ir[25:21];
    assign c.rt = c.tuse_rt == TUSE_NONE ? 5'd0 : ir[20:16];
    assign c.tnew = ld ? 2'd2 : (r_alu || i_alu_rs || lui || mf) ? 2'd1 : 2'd0;
    assign c.is_md = md_st || mf || mt;
    assign c.is_md_start = md_st;
    assign c.is_jal = jal;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, flush and forwarding control for the five-stage pipeline
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_D_in,
    input  logic [31:0] IR_E_in,
    input  logic [31:0] IR_M_in,
    input  logic [31:0] IR_W_in,
    output logic        pc_en,
    output logic        D_en,
    output logic        E_clr,
    output logic [1:0]  MF_CMPA_D_sel,
    output logic [1:0]  MF_CMPB_D_sel,
    output logic [2:0]  MF_ALUA_E_sel,
    output logic [2:0]  MF_ALUB_E_sel,
    output logic [2:0]  MF_MemData_E_sel,
    output logic [1:0]  MF_DMWD_M_sel,
    output logic        md_busy,
    output logic [15:0] stall_cnt
);
    cls_t d, e, m, w;
    logic [3:0] cnt;
    logic stall, md_stall, unused_cls;

    instr_class u_d (.ir(IR_D_in), .c(d));
    instr_class u_e (.ir(IR_E_in), .c(e));
    instr_class u_m (.ir(IR_M_in), .c(m));
    instr_class u_w (.ir(IR_W_in), .c(w));

    assign unused_cls = ^{d.dst, d.tnew, d.is_md_start, d.is_jal, e.tuse_rs, e.tuse_rt, e.is_md, e.is_jal,
                          m.rs, m.tuse_rs, m.tuse_rt, m.is_md, m.is_md_start,
                          w.rs, w.rt, w.tuse_rs, w.tuse_rt, w.tnew, w.is_md, w.is_md_start, w.is_jal};

    assign md_stall = d.is_md && (e.is_md_start || cnt != 4'd0);
    assign stall = !reset && (stall_on(d.rs, d.tuse_rs, e.dst, e.tnew, m.dst, m.tnew) ||
                              stall_on(d.rt, d.tuse_rt, e.dst, e.tnew, m.dst, m.tnew) || md_stall);
    assign pc_en = !stall;
    assign D_en  = !stall;
    assign E_clr = stall;
    assign md_busy = !reset && cnt != 4'd0;

    assign MF_CMPA_D_sel    = reset ? 2'd0 : fwd_d(d.rs, e.dst, e.tnew, m.dst, m.tnew, m.is_jal);
    assign MF_CMPB_D_sel    = reset ? 2'd0 : fwd_d(d.rt, e.dst, e.tnew, m.dst, m.tnew, m.is_jal);
    assign MF_ALUA_E_sel    = reset ? 3'd0 : fwd_e(e.rs, m.dst, m.tnew, m.is_jal, w.dst);
    assign MF_ALUB_E_sel    = reset ? 3'd0 : fwd_e(e.rt, m.dst, m.tnew, m.is_jal, w.dst);
    assign MF_MemData_E_sel = MF_ALUB_E_sel;
    assign MF_DMWD_M_sel    = {1'b0, !reset && hit(w.dst, m.rt)};

    // mult/div busy window: reload when an md op sits in E, otherwise count down to idle
    always_ff @(posedge clk) begin
        if (reset) cnt <= 4'd0;
        else if (e.is_md_start) cnt <= IR_E_in[1] ? 4'(DIV_CYC) : 4'(MULT_CYC);
        else if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end

    // saturating count of cycles spent stalled
    always_ff @(posedge clk) begin
        if (reset) stall_cnt <= 16'd0;
        else if (stall && stall_cnt != 16'hffff) stall_cnt <= stall_cnt + 16'd1;
    end

    // the MD stall keeps a second md op out of E while the unit is still busy
    assert property (@(posedge clk) disable iff (reset) !(e.is_md_start && cnt != 4'd0));
endmodule
